// File: rtl/tpu_pkg.sv
// Shared definitions for the LeNet-5 TPU layer sequencer: FSM states, core/DMA
// command codes and the per-layer geometry table.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DMA_REQ,
        DMA_WAIT,
        FINISH
    } state_e;

    localparam logic [1:0] CORE_NONE = 2'b00;
    localparam logic [1:0] CORE_CONV = 2'b01;
    localparam logic [1:0] CORE_FC   = 2'b10;

    localparam logic [1:0] DMA_CONV1     = 2'd0;
    localparam logic [1:0] DMA_CONV2     = 2'd1;
    localparam logic [1:0] DMA_FC        = 2'd2;
    localparam logic [1:0] DMA_WRITEBACK = 2'd3;

    localparam logic [4:0] C1_OFMAP    = 5'd28;
    localparam logic [5:0] C1_ICH      = 6'd1;
    localparam logic [4:0] C1_DONE_BIT = 5'd5;
    localparam logic [4:0] C2_OFMAP    = 5'd10;
    localparam logic [5:0] C2_ICH      = 6'd6;
    localparam logic [4:0] C2_DONE_BIT = 5'd15;
    localparam logic [8:0] FC1_IN      = 9'd400;
    localparam logic [6:0] FC1_OUT     = 7'd120;
    localparam logic [8:0] FC2_IN      = 9'd120;
    localparam logic [6:0] FC2_OUT     = 7'd84;
    localparam logic [8:0] FC3_IN      = 9'd84;
    localparam logic [6:0] FC3_OUT     = 7'd10;
    localparam logic [4:0] FC_DONE_BIT = 5'd16;

    localparam logic [2:0] LAST_LAYER = 3'd4;

    typedef struct packed {
        logic [4:0] ofmapSize;
        logic [5:0] ifmapCh;
        logic [8:0] inNodes;
        logic [6:0] outNodes;
    } geom_t;

    // Conv layers leave the node counts at 0; FC layers leave the fmap fields at 0.
    localparam geom_t GEOM_TABLE [0:4] = '{
        '{C1_OFMAP, C1_ICH, 9'd0,   7'd0},
        '{C2_OFMAP, C2_ICH, 9'd0,   7'd0},
        '{5'd0,     6'd0,   FC1_IN, FC1_OUT},
        '{5'd0,     6'd0,   FC2_IN, FC2_OUT},
        '{5'd0,     6'd0,   FC3_IN, FC3_OUT}
    };

endpackage

// File: rtl/tpu_layer_ctrl.sv
// Layer sequencer: walks conv1 -> conv2 -> fc1 -> fc2 -> fc3, starting the core,
// waiting for each layer's done bit and handing off to the DMA engine in between.
module tpu_layer_ctrl
    import tpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        start_dma_o,
    output logic [1:0]  nth_conv_o,
    input  logic        dma_done_i,
    output logic [4:0]  ofmap_size_o,
    output logic [5:0]  ifmap_ch_o,
    output logic [8:0]  in_node_num_o,
    output logic [6:0]  out_node_num_o,
    input  logic [16:0] done,
    output logic [1:0]  start_core_o,
    output logic        cnn_done_o
);

    state_e     state_q;
    logic [2:0] layer_q;
    geom_t      geom_q;
    logic [1:0] startCore_q;
    logic       startDma_q;
    logic [1:0] nthConv_q;
    logic       cnnDone_q;

    logic [2:0] layerNext;
    geom_t      geom_d;
    logic [1:0] core_d;
    logic [4:0] watchIdx;
    logic [1:0] job_d;
    logic       watchedDone;

    // Lookup for the layer about to be loaded (layer 0 from IDLE, else the next one).
    always_comb begin
        layerNext = (state_q == IDLE) ? 3'd0 : layer_q + 3'd1;
        geom_d    = '0;
        case (layerNext)
            3'd0:    geom_d = GEOM_TABLE[0];
            3'd1:    geom_d = GEOM_TABLE[1];
            3'd2:    geom_d = GEOM_TABLE[2];
            3'd3:    geom_d = GEOM_TABLE[3];
            3'd4:    geom_d = GEOM_TABLE[4];
            default: geom_d = '0;
        endcase
        core_d = (layerNext < 3'd2) ? CORE_CONV : CORE_FC;
    end

    // Completion bit and DMA job for the layer currently running.
    always_comb begin
        watchIdx = FC_DONE_BIT;
        job_d    = DMA_WRITEBACK;
        case (layer_q)
            3'd0: begin
                watchIdx = C1_DONE_BIT;
                job_d    = DMA_CONV1;
            end
            3'd1: begin
                watchIdx = C2_DONE_BIT;
                job_d    = DMA_CONV2;
            end
            3'd2, 3'd3: begin
                watchIdx = FC_DONE_BIT;
                job_d    = DMA_FC;
            end
            default: begin
                watchIdx = FC_DONE_BIT;
                job_d    = DMA_WRITEBACK;
            end
        endcase
        watchedDone = done[watchIdx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            layer_q     <= '0;
            geom_q      <= '0;
            startCore_q <= CORE_NONE;
            startDma_q  <= 1'b0;
            nthConv_q   <= '0;
            cnnDone_q   <= 1'b0;
        end else begin
            startCore_q <= CORE_NONE;
            startDma_q  <= 1'b0;
            cnnDone_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        layer_q     <= '0;
                        geom_q      <= geom_d;
                        startCore_q <= core_d;
                        state_q     <= START;
                    end
                end
                START: state_q <= RUN;
                RUN: begin
                    if (watchedDone) begin
                        startDma_q <= 1'b1;
                        nthConv_q  <= job_d;
                        state_q    <= DMA_REQ;
                    end
                end
                DMA_REQ: state_q <= DMA_WAIT;
                DMA_WAIT: begin
                    if (dma_done_i) begin
                        if (layer_q == LAST_LAYER) begin
                            cnnDone_q <= 1'b1;
                            state_q   <= FINISH;
                        end else begin
                            layer_q     <= layerNext;
                            geom_q      <= geom_d;
                            startCore_q <= core_d;
                            state_q     <= START;
                        end
                    end
                end
                FINISH: begin
                    geom_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_core_o   = startCore_q;
    assign start_dma_o    = startDma_q;
    assign nth_conv_o     = nthConv_q;
    assign cnn_done_o     = cnnDone_q;
    assign ofmap_size_o   = geom_q.ofmapSize;
    assign ifmap_ch_o     = geom_q.ifmapCh;
    assign in_node_num_o  = geom_q.inNodes;
    assign out_node_num_o = geom_q.outNodes;

endmodule

// File: tb/tb_tpu_layer_ctrl.sv
// Directed bench for tpu_layer_ctrl: full network run, restart, ignored inputs
// and a reset in the middle of the fc1 DMA handoff.
module tb_tpu_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startI;
    logic        startDma;
    logic [1:0]  nthConv;
    logic        dmaDoneI;
    logic [4:0]  ofmapSize;
    logic [5:0]  ifmapCh;
    logic [8:0]  inNodeNum;
    logic [6:0]  outNodeNum;
    logic [16:0] doneI;
    logic [1:0]  startCore;
    logic        cnnDone;

    int assertCount = 0;
    int failCount   = 0;
    int curNth      = 0;

    // Hand-written per-layer expectations: conv1, conv2, fc1, fc2, fc3.
    int expOfmap [5] = '{28, 10, 0, 0, 0};
    int expIch   [5] = '{1, 6, 0, 0, 0};
    int expIn    [5] = '{0, 0, 400, 120, 84};
    int expOut   [5] = '{0, 0, 120, 84, 10};
    int expCore  [5] = '{1, 1, 2, 2, 2};
    int expBit   [5] = '{5, 15, 16, 16, 16};
    int expNth   [5] = '{0, 1, 2, 2, 3};

    tpu_layer_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (startI),
        .start_dma_o    (startDma),
        .nth_conv_o     (nthConv),
        .dma_done_i     (dmaDoneI),
        .ofmap_size_o   (ofmapSize),
        .ifmap_ch_o     (ifmapCh),
        .in_node_num_o  (inNodeNum),
        .out_node_num_o (outNodeNum),
        .done           (doneI),
        .start_core_o   (startCore),
        .cnn_done_o     (cnnDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive inputs, let one rising edge pass, then settle 1 ns before sampling.
    task automatic applyStimulus(input bit st, input logic [16:0] d, input bit dd);
        startI   = st;
        doneI    = d;
        dmaDoneI = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic expectOutputs(input string tag, input int core, input int dma, input int nth,
                                 input int ofm, input int ich, input int inN, input int outN,
                                 input int cnn);
        checkOutput({tag, ".start_core"}, int'(startCore), core);
        checkOutput({tag, ".start_dma"}, int'(startDma), dma);
        checkOutput({tag, ".nth_conv"}, int'(nthConv), nth);
        checkOutput({tag, ".ofmap"}, int'(ofmapSize), ofm);
        checkOutput({tag, ".ifmap_ch"}, int'(ifmapCh), ich);
        checkOutput({tag, ".in_nodes"}, int'(inNodeNum), inN);
        checkOutput({tag, ".out_nodes"}, int'(outNodeNum), outN);
        checkOutput({tag, ".cnn_done"}, int'(cnnDone), cnn);
    endtask

    task automatic expectLayer(input string tag, input int l, input bit coreOn, input bit dmaOn,
                               input bit cnnOn);
        expectOutputs(tag, coreOn ? expCore[l] : 0, int'(dmaOn), curNth,
                      expOfmap[l], expIch[l], expIn[l], expOut[l], int'(cnnOn));
    endtask

    task automatic expectIdle(input string tag);
        expectOutputs(tag, 0, 0, curNth, 0, 0, 0, 0, 0);
    endtask

    // Starts in the START cycle of layer l; ends in its DMA_WAIT cycle.
    task automatic runLayer(input int l);
        logic [16:0] mask;
        string       tag;
        mask = 17'd1 << expBit[l];
        tag  = $sformatf("L%0d", l);
        applyStimulus(1'b0, mask, 1'b0);
        expectLayer({tag, ".run"}, l, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, ~mask, 1'b1);
        expectLayer({tag, ".ignored"}, l, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, mask, 1'b1);
        curNth = expNth[l];
        expectLayer({tag, ".dmaReq"}, l, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, mask, 1'b0);
        expectLayer({tag, ".dmaWait"}, l, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runNetwork(input string tag);
        applyStimulus(1'b1, 17'd0, 1'b0);
        expectLayer({tag, ".start0"}, 0, 1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 5; l++) begin
            runLayer(l);
            applyStimulus(1'b0, 17'd0, 1'b1);
            if (l < 4) expectLayer($sformatf("%s.start%0d", tag, l + 1), l + 1, 1'b1, 1'b0, 1'b0);
            else       expectLayer({tag, ".finish"}, 4, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 17'd0, 1'b0);
        expectIdle({tag, ".idleAfter"});
        applyStimulus(1'b0, 17'd0, 1'b0);
        expectIdle({tag, ".idleHold"});
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 17'd0, 1'b0);
        applyStimulus(1'b0, 17'd0, 1'b0);
        curNth = 0;
        expectIdle("reset");
        rst_n = 1'b1;

        applyStimulus(1'b0, 17'd1 << 5, 1'b0);
        expectIdle("idleDone5");
        applyStimulus(1'b0, 17'd0, 1'b1);
        expectIdle("idleDmaDone");

        runNetwork("run1");
        runNetwork("run2");

        applyStimulus(1'b1, 17'd0, 1'b0);
        expectLayer("run3.start0", 0, 1'b1, 1'b0, 1'b0);
        runLayer(0);
        applyStimulus(1'b0, 17'd0, 1'b1);
        expectLayer("run3.start1", 1, 1'b1, 1'b0, 1'b0);
        runLayer(1);
        applyStimulus(1'b0, 17'd0, 1'b1);
        expectLayer("run3.start2", 2, 1'b1, 1'b0, 1'b0);
        runLayer(2);

        rst_n = 1'b0;
        applyStimulus(1'b0, 17'd0, 1'b1);
        curNth = 0;
        expectIdle("midReset");
        rst_n = 1'b1;
        applyStimulus(1'b0, 17'd1 << 16, 1'b1);
        expectIdle("postReset");
        applyStimulus(1'b1, 17'd0, 1'b0);
        expectLayer("restart.start0", 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 17'd0, 1'b0);
        expectLayer("restart.run", 0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
